// File: rtl/work_dispatcher.sv
// work_dispatcher
//   Fans one work unit out to NUM_CORES hash cores, each searching a disjoint
//   nonce slice, and gathers found nonces through a round-robin arbiter into a
//   result FIFO that the serial side drains.
//
// Ports
//   clk, rst_n         clock, async active-low reset
//   new_work/work_data upstream work handshake (level), got_work pulse back
//   core_work          latched work broadcast to every core
//   core_base          per-core start nonce, slice i = i << (NONCE_W-log2(NUM_CORES))
//   core_start/abort   per-core one-cycle job control pulses
//   core_done/found    per-core status levels, core_nonce valid while found
//   core_found_ack     one-cycle pulse: nonce taken this cycle
//   new_result/result_data/result_ready  result FIFO head and pop handshake
//   exhausted          every slice searched and nothing left to report
module work_dispatcher #(
    parameter int NUM_CORES  = 4,
    parameter int WORK_W     = 640,
    parameter int NONCE_W    = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         new_work,
    input  logic [WORK_W-1:0]            work_data,
    output logic                         got_work,
    output logic [WORK_W-1:0]            core_work,
    output logic [NUM_CORES*NONCE_W-1:0] core_base,
    output logic [NUM_CORES-1:0]         core_start,
    output logic [NUM_CORES-1:0]         core_abort,
    input  logic [NUM_CORES-1:0]         core_done,
    input  logic [NUM_CORES-1:0]         core_found,
    input  logic [NUM_CORES*NONCE_W-1:0] core_nonce,
    output logic [NUM_CORES-1:0]         core_found_ack,
    output logic                         new_result,
    output logic [NONCE_W-1:0]           result_data,
    input  logic                         result_ready,
    output logic                         exhausted
);

    localparam int LOG2N = $clog2(NUM_CORES);
    localparam int IDX_W = (NUM_CORES > 1) ? LOG2N : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    function automatic logic [NUM_CORES*NONCE_W-1:0] base_init();
        logic [NUM_CORES*NONCE_W-1:0] b;
        b = '0;
        for (int i = 0; i < NUM_CORES; i++)
            b[i*NONCE_W +: NONCE_W] = NONCE_W'(i) << (NONCE_W - LOG2N);
        return b;
    endfunction

    localparam logic [NUM_CORES*NONCE_W-1:0] BASE = base_init();

    typedef enum logic [1:0] {IDLE, LOAD, RUN, EXHAUST} state_e;

    state_e                       state_q;
    logic                         got_work_q;
    logic [NUM_CORES-1:0]         core_start_q, core_abort_q;
    logic [WORK_W-1:0]            core_work_q;
    logic [NUM_CORES*NONCE_W-1:0] core_base_q;

    logic [IDX_W-1:0] rr_q, rr_d;
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [NONCE_W-1:0] mem_q [FIFO_DEPTH];

    logic             load_go, arb_en, fifo_full, fifo_empty, push, pop;
    logic             grant_vld;
    logic [IDX_W-1:0] grant_idx, cand;
    logic [NONCE_W-1:0] nonce_sel;

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);

    // Entering LOAD: straight from IDLE/EXHAUST, or on the cycle after the
    // abort pulse in RUN (abort gives the cores one cycle to drop the old job).
    assign load_go = (new_work && (state_q == IDLE || state_q == EXHAUST)) ||
                     (state_q == RUN && (|core_abort_q));

    // No grants while a new job is pending or being aborted, so stale nonces
    // cannot slip into the freshly flushed FIFO.
    assign arb_en = (state_q == RUN) && !(|core_abort_q) && !new_work && !fifo_full;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (arb_en) begin
            for (int k = 0; k < NUM_CORES; k++) begin
                cand = IDX_W'((int'(rr_q) + k) % NUM_CORES);
                if (!grant_vld && core_found[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    always_comb begin
        core_found_ack = '0;
        if (grant_vld) core_found_ack[grant_idx] = 1'b1;
    end

    assign nonce_sel = core_nonce[int'(grant_idx)*NONCE_W +: NONCE_W];
    assign push      = grant_vld;
    assign pop       = result_ready && !fifo_empty;
    assign rr_d      = grant_vld ? IDX_W'((int'(grant_idx) + 1) % NUM_CORES) : rr_q;

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (load_go) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (push) wr_d = wr_q + 1'b1;
            if (pop)  rd_d = rd_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (!push && pop) count_d = count_q - 1'b1;
        end
    end

    // Job control FSM; every output it drives is registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            got_work_q   <= 1'b0;
            core_start_q <= '0;
            core_abort_q <= '0;
            core_work_q  <= '0;
            core_base_q  <= '0;
        end else begin
            got_work_q   <= 1'b0;
            core_start_q <= '0;
            core_abort_q <= '0;
            core_base_q  <= BASE;
            if (load_go) begin
                state_q      <= LOAD;
                core_work_q  <= work_data;
                got_work_q   <= 1'b1;
                core_start_q <= '1;
            end else begin
                case (state_q)
                    LOAD: state_q <= RUN;
                    RUN: begin
                        if (new_work)
                            core_abort_q <= '1;
                        else if ((&core_done) && !(|core_found))
                            state_q <= EXHAUST;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q    <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            rr_q    <= rr_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: result_data is masked to 0 while empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= nonce_sel;
    end

    assign got_work    = got_work_q;
    assign core_work   = core_work_q;
    assign core_base   = core_base_q;
    assign core_start  = core_start_q;
    assign core_abort  = core_abort_q;
    assign new_result  = !fifo_empty;
    assign result_data = fifo_empty ? '0 : mem_q[rd_q];
    assign exhausted   = (state_q == EXHAUST) && fifo_empty && !new_work;

endmodule

// File: tb/tb_work_dispatcher.sv
module tb_work_dispatcher;
    localparam int NC = 4;
    localparam int NW = 32;
    localparam int WW = 640;
    localparam int FD = 8;

    logic clk = 0, rst_n = 0;
    logic new_work = 0, result_ready = 0;
    logic [WW-1:0] work_data = '0;
    logic got_work, new_result, exhausted;
    logic [WW-1:0] core_work;
    logic [NC*NW-1:0] core_base, core_nonce;
    logic [NC-1:0] core_start, core_abort, core_found_ack;
    logic [NC-1:0] core_done = '0, found_v = '0;
    logic [NW-1:0] result_data;

    work_dispatcher #(.NUM_CORES(NC), .WORK_W(WW), .NONCE_W(NW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rst_n), .new_work(new_work), .work_data(work_data),
        .got_work(got_work), .core_work(core_work), .core_base(core_base),
        .core_start(core_start), .core_abort(core_abort), .core_done(core_done),
        .core_found(found_v), .core_nonce(core_nonce), .core_found_ack(core_found_ack),
        .new_result(new_result), .result_data(result_data), .result_ready(result_ready),
        .exhausted(exhausted));

    always #10 clk = ~clk;

    int total = 0, bad = 0;
    int ack_cnt = 0;
    logic [NW-1:0] exp_q[$];

    // Core model: each core reports its nonce list one entry at a time, drops
    // found the cycle after an ack and raises the next entry a cycle later.
    logic [NW-1:0] lst [NC][4];
    int            len [NC];
    int            idx [NC];
    logic [NC-1:0] gap = '0, ack_last = '0;
    logic [NW-1:0] nonce_arr [NC];
    logic          nw_next = 0, rr_next = 0;

    always_comb begin
        core_nonce = '0;
        for (int i = 0; i < NC; i++) core_nonce[i*NW +: NW] = nonce_arr[i];
    end

    // One cycle: drive at the falling edge, sample 1 time unit later.
    task automatic tick();
        logic [NW-1:0] e;
        @(negedge clk);
        new_work     = nw_next;
        result_ready = rr_next;
        for (int i = 0; i < NC; i++)
            if (gap[i]) begin
                gap[i] = 1'b0;
                if (idx[i] < len[i]) begin
                    found_v[i]   = 1'b1;
                    nonce_arr[i] = lst[i][idx[i]];
                end
            end
        for (int i = 0; i < NC; i++)
            if (ack_last[i]) begin
                found_v[i] = 1'b0;
                idx[i]++;
                gap[i] = 1'b1;
            end
        #1;
        ack_last = core_found_ack;
        ack_cnt += $countones(core_found_ack);
        if (new_result && result_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pop got=%h expected=<none>", result_data);
            end else begin
                e = exp_q.pop_front();
                if (result_data !== e) begin
                    bad++;
                    $display("FAIL pop_data got=%h expected=%h", result_data, e);
                end
            end
        end
    endtask

    task automatic clear_model();
        found_v = '0; gap = '0; ack_last = '0;
        for (int i = 0; i < NC; i++) begin
            len[i] = 0; idx[i] = 0; nonce_arr[i] = '0;
        end
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 0; nw_next = 0; rr_next = 0; new_work = 0; result_ready = 0;
        core_done = '0;
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1;
        tick(); tick();
    endtask

    task automatic load_work(input logic [WW-1:0] w);
        work_data = w; nw_next = 1;
        tick();
        total++;
        if (got_work !== 1'b0) begin bad++; $display("FAIL got_work_early got=%b expected=0", got_work); end
        nw_next = 0;
        tick();
        total++;
        if (got_work !== 1'b1 || core_start !== 4'b1111 || core_work !== w) begin
            bad++;
            $display("FAIL load_pulse got_work=%b core_start=%b work_ok=%b expected 1 1111 1",
                     got_work, core_start, core_work === w);
        end
        tick();
        total++;
        if (got_work !== 1'b0 || core_start !== 4'b0000) begin
            bad++; $display("FAIL load_single got_work=%b core_start=%b expected 0 0000", got_work, core_start);
        end
    endtask

    function automatic logic [WW-1:0] rand_work();
        logic [WW-1:0] w;
        for (int i = 0; i < WW/32; i++) w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    task automatic test_reset();
        rst_n = 0;
        #3;
        total++;
        if (got_work !== 0 || core_start !== 0 || core_abort !== 0 || core_base !== '0 ||
            new_result !== 0 || result_data !== 0 || exhausted !== 0 || core_found_ack !== 0) begin
            bad++; $display("FAIL reset_outputs got nonzero output, expected all 0");
        end
        do_reset();
    endtask

    task automatic test_load();
        logic [NC*NW-1:0] eb;
        eb = {32'hC000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        total++;
        if (core_base !== eb) begin bad++; $display("FAIL core_base got=%h expected=%h", core_base, eb); end
        load_work(rand_work());
    endtask

    task automatic test_rr_pair();
        do_reset();
        load_work(rand_work());
        lst[1][0] = 32'h11; len[1] = 1;
        lst[3][0] = 32'h33; len[3] = 1;
        gap = 4'b1010; rr_next = 1;
        exp_q.push_back(32'h11); exp_q.push_back(32'h33);
        tick();
        total++;
        if (core_found_ack !== 4'b0010) begin bad++; $display("FAIL rr_first_ack got=%b expected=0010", core_found_ack); end
        tick();
        total++;
        if (core_found_ack !== 4'b1000) begin bad++; $display("FAIL rr_second_ack got=%b expected=1000", core_found_ack); end
        for (int t = 0; t < 10 && (exp_q.size() != 0 || new_result); t++) tick();
        total++;
        if (exp_q.size() != 0 || new_result !== 1'b0) begin
            bad++; $display("FAIL rr_drain left=%0d new_result=%b expected 0 0", exp_q.size(), new_result);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        load_work(rand_work());
        lst[0][0] = 32'hA0; lst[0][1] = 32'hA1; lst[0][2] = 32'hA2; len[0] = 3;
        lst[1][0] = 32'hB0; lst[1][1] = 32'hB1; lst[1][2] = 32'hB2; len[1] = 3;
        lst[2][0] = 32'hC0; lst[2][1] = 32'hC1; len[2] = 2;
        lst[3][0] = 32'hD0; lst[3][1] = 32'hD1; len[3] = 2;
        foreach (exp_q[i]) ;
        exp_q = '{32'hA0, 32'hB0, 32'hC0, 32'hD0, 32'hA1, 32'hB1, 32'hC1, 32'hD1, 32'hA2, 32'hB2};
        gap = 4'b1111; rr_next = 0; ack_cnt = 0;
        repeat (12) tick();
        total++;
        if (ack_cnt != 8) begin bad++; $display("FAIL bp_fill_acks got=%0d expected=8", ack_cnt); end
        total++;
        if (found_v !== 4'b0011) begin bad++; $display("FAIL bp_held got=%b expected=0011", found_v); end
        rr_next = 1;
        tick();
        total++;
        if (core_found_ack !== 4'b0000) begin bad++; $display("FAIL bp_full_noack got=%b expected=0000", core_found_ack); end
        rr_next = 0;
        tick();
        total++;
        if (core_found_ack !== 4'b0001) begin bad++; $display("FAIL bp_ack_after_pop got=%b expected=0001", core_found_ack); end
        tick();
        total++;
        if (core_found_ack !== 4'b0000) begin bad++; $display("FAIL bp_refull got=%b expected=0000", core_found_ack); end
        rr_next = 1;
        for (int t = 0; t < 40 && (exp_q.size() != 0 || new_result); t++) tick();
        total++;
        if (exp_q.size() != 0 || new_result !== 1'b0 || ack_cnt != 10) begin
            bad++; $display("FAIL bp_drain left=%0d new_result=%b acks=%0d expected 0 0 10",
                            exp_q.size(), new_result, ack_cnt);
        end
    endtask

    task automatic test_abort();
        logic [WW-1:0] w2;
        do_reset();
        load_work(rand_work());
        lst[0][0] = 32'hE0; len[0] = 1;
        lst[1][0] = 32'hE1; len[1] = 1;
        lst[2][0] = 32'hE2; len[2] = 1;
        gap = 4'b0111; rr_next = 0;
        repeat (5) tick();
        total++;
        if (new_result !== 1'b1) begin bad++; $display("FAIL abort_queued got=%b expected=1", new_result); end
        w2 = rand_work(); work_data = w2;
        lst[3][0] = 32'hEE; len[3] = 1; gap[3] = 1'b1;
        nw_next = 1;
        tick();
        total++;
        if (core_found_ack !== 4'b0000) begin bad++; $display("FAIL abort_req_noack got=%b expected=0000", core_found_ack); end
        tick();
        total++;
        if (core_abort !== 4'b1111 || core_found_ack !== 4'b0000 || got_work !== 1'b0) begin
            bad++; $display("FAIL abort_pulse abort=%b ack=%b got_work=%b expected 1111 0000 0",
                            core_abort, core_found_ack, got_work);
        end
        found_v = '0; gap = '0; ack_last = '0;
        nw_next = 0;
        tick();
        exp_q.delete();
        total++;
        if (got_work !== 1'b1 || core_start !== 4'b1111 || core_abort !== 4'b0000 ||
            new_result !== 1'b0 || core_work !== w2) begin
            bad++; $display("FAIL abort_load got_work=%b start=%b abort=%b new_result=%b expected 1 1111 0000 0",
                            got_work, core_start, core_abort, new_result);
        end
        tick();
        total++;
        if (new_result !== 1'b0 || got_work !== 1'b0) begin
            bad++; $display("FAIL abort_after new_result=%b got_work=%b expected 0 0", new_result, got_work);
        end
    endtask

    task automatic test_exhaust();
        do_reset();
        load_work(rand_work());
        total++;
        if (exhausted !== 1'b0) begin bad++; $display("FAIL exh_run got=%b expected=0", exhausted); end
        core_done = '1;
        tick();
        total++;
        if (exhausted !== 1'b1) begin bad++; $display("FAIL exh_set got=%b expected=1", exhausted); end
        nw_next = 1;
        tick();
        total++;
        if (exhausted !== 1'b0) begin bad++; $display("FAIL exh_drop got=%b expected=0", exhausted); end
        nw_next = 0;
        tick();
        total++;
        if (got_work !== 1'b1 || core_abort !== 4'b0000 || exhausted !== 1'b0) begin
            bad++; $display("FAIL exh_reload got_work=%b abort=%b exhausted=%b expected 1 0000 0",
                            got_work, core_abort, exhausted);
        end
        core_done = '0;
        tick();
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        load_work(rand_work());
        lst[0][0] = 32'h61; len[0] = 1;
        lst[1][0] = 32'h62; len[1] = 1;
        gap = 4'b0011; rr_next = 0;
        repeat (4) tick();
        total++;
        if (new_result !== 1'b1) begin bad++; $display("FAIL mid_queued got=%b expected=1", new_result); end
        #2 rst_n = 0;
        #1;
        total++;
        if (got_work !== 0 || core_start !== 0 || core_abort !== 0 || core_base !== '0 || core_work !== '0 ||
            new_result !== 0 || result_data !== 0 || exhausted !== 0 || core_found_ack !== 0) begin
            bad++; $display("FAIL mid_reset_async new_result=%b abort=%b base_zero=%b expected all 0",
                            new_result, core_abort, core_base === '0);
        end
        clear_model();
        @(negedge clk);
        rst_n = 1;
        tick();
        total++;
        if (new_result !== 1'b0 || core_abort !== 4'b0000 || result_data !== '0) begin
            bad++; $display("FAIL mid_release new_result=%b abort=%b data=%h expected 0 0000 0",
                            new_result, core_abort, result_data);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_rr_pair();
        test_backpressure();
        test_abort();
        test_exhaust();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
